// File: rtl/dmem_latency_responder.sv
// dmem_latency_responder: single-outstanding load/store responder with programmable wait states (optional DMEM_JITTER_EN adds 0-3 LFSR-driven extra wait cycles)
module dmem_latency_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter bit INIT_ZERO   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  input  logic [3:0]  byteEnable,
  input  logic        storeValid,
  input  logic        loadValid,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  state_t          r_state;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic            r_is_store;
  logic [4:0]      r_cnt;
  logic [4:0]      r_target;
  logic [31:0]     r_mem [DEPTH_WORDS] = '{default: INIT_ZERO ? 32'h0 : {32{1'bx}}};
  logic            w_accept;
  logic            w_issue;
  logic            w_idle;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_wdata;
  logic [3:0]      w_be;
  logic            w_store;
  logic [4:0]      w_target;
  logic            w_unused;
  assign w_unused = ^address;
  assign w_idle   = r_state == IDLE;
  assign w_accept = w_idle && (storeValid || loadValid);
  // A zero-latency request responds on its acceptance edge, so the live inputs stand in for the latched request
  assign w_idx    = w_idle ? address[2 +: AW] : r_idx;
  assign w_wdata  = w_idle ? storeData : r_wdata;
  assign w_be     = w_idle ? byteEnable : r_be;
  assign w_store  = w_idle ? storeValid : r_is_store;
  assign w_issue  = (w_accept && w_target == 5'd0) || (r_state == WAIT && r_cnt + 5'd1 == r_target);
`ifdef DMEM_JITTER_EN
  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_next;
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_target    = 5'(LATENCY) + {3'b000, w_lfsr_next[1:0]};
  // LFSR advances once per accepted request; its fresh low bits stretch that request
  always_ff @(posedge clock) begin
    if (reset) r_lfsr <= 8'hA5;
    else if (w_accept) r_lfsr <= w_lfsr_next;
  end
`else
  assign w_target = 5'(LATENCY);
`endif
  // Byte-lane write lands on the edge that issues the store response; reset suppresses it
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (!reset && w_issue && w_store && w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
  end
  // Request FSM with registered response pulses, busy flag and load data
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= 5'd0;
      r_target      <= 5'd0;
      r_idx         <= '0;
      r_wdata       <= 32'h0;
      r_be          <= 4'h0;
      r_is_store    <= 1'b0;
      loadData      <= 32'h0;
      loadDataValid <= 1'b0;
      storeComplete <= 1'b0;
      busy          <= 1'b0;
    end else begin
      loadDataValid <= w_issue && !w_store;
      storeComplete <= w_issue && w_store;
      if (w_issue && !w_store) loadData <= r_mem[w_idx];
      case (r_state)
        IDLE: if (w_accept) begin
          r_idx      <= address[2 +: AW];
          r_wdata    <= storeData;
          r_be       <= byteEnable;
          r_is_store <= storeValid;
          r_cnt      <= 5'd0;
          r_target   <= w_target;
          r_state    <= w_issue ? RESPOND : WAIT;
          busy       <= !w_issue;
        end
        WAIT: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_issue) begin
            r_state <= RESPOND;
            busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_latency_responder.sv
// tb_dmem_latency_responder: randomized scoreboard bench for dmem_latency_responder
module tb_dmem_latency_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = 32'h0;
  logic [31:0] storeData = 32'h0;
  logic [3:0]  byteEnable = 4'h0;
  logic        storeValid = 1'b0;
  logic        loadValid = 1'b0;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        busy;
  typedef struct {
    bit          st;
    logic [31:0] d;
    int          acc;
    int          due;
  } exp_t;
  exp_t        q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_ld = 32'h0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  bit          busy_chk_en = 1'b1;
  dmem_latency_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .INIT_ZERO(1'b1)) dut (
    .clock(clock), .reset(reset), .address(address), .storeData(storeData),
    .byteEnable(byteEnable), .storeValid(storeValid), .loadValid(loadValid),
    .loadData(loadData), .loadDataValid(loadDataValid), .storeComplete(storeComplete), .busy(busy)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // Monitor: pops the scoreboard on every response pulse and checks busy/loadData every cycle
  always @(negedge clock) begin
    exp_t e;
    bit   eb;
    if (reset) last_ld = 32'h0;
    else if (mon_en) begin
      eb = busy_chk_en && q.size() > 0 && cyc >= q[0].acc && cyc < q[0].due;
      checks++;
      if (busy !== eb) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
      end
      if (loadDataValid || storeComplete) begin
        checks++;
        if (loadDataValid && storeComplete) begin
          failures++;
          $display("FAIL both_pulses cyc=%0d got=11 exp=one", cyc);
        end
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp cyc=%0d ld=%b st=%b exp=none", cyc, loadDataValid, storeComplete);
        end else begin
          e = q.pop_front();
          checks++;
          if (storeComplete !== e.st) begin
            failures++;
            $display("FAIL resp_kind cyc=%0d got_store=%b exp_store=%b", cyc, storeComplete, e.st);
          end
          checks++;
          if (cyc != e.due) begin
            failures++;
            $display("FAIL resp_cycle got=%0d exp=%0d", cyc, e.due);
          end
          if (!e.st) begin
            last_ld = e.d;
            checks++;
            if (loadData !== e.d) begin
              failures++;
              $display("FAIL load_data cyc=%0d got=%h exp=%h", cyc, loadData, e.d);
            end
          end
        end
      end else begin
        checks++;
        if (loadData !== last_ld) begin
          failures++;
          $display("FAIL load_hold cyc=%0d got=%h exp=%h", cyc, loadData, last_ld);
        end
      end
    end
  end
  task automatic do_req(input bit st, input bit ld, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit use_exp, input logic [31:0] exp_d);
    exp_t e;
    int   idx;
    bit   got;
    idx = int'((a >> 2) % DEPTH);
    address = a; storeData = d; byteEnable = be; storeValid = st; loadValid = ld;
    e.st = st; e.acc = cyc + 1; e.due = cyc + 1 + LAT; e.d = 32'h0;
    if (st) begin
      for (int i = 0; i < 4; i++) if (be[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
    end else e.d = use_exp ? exp_d : ref_mem[idx];
    q.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      got = loadDataValid || storeComplete;
    end
    storeValid = 1'b0; loadValid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL timeout addr=%h got=no_resp exp=resp", a);
    end
    @(negedge clock);
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask
  initial begin
    logic [31:0] a;
    int          r;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({loadData, loadDataValid, storeComplete, busy} !== 35'h0) begin
      failures++;
      $display("FAIL reset_state got=%h/%b/%b/%b exp=0", loadData, loadDataValid, storeComplete, busy);
    end
    reset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({loadData, loadDataValid, storeComplete, busy} !== 35'h0) begin
        failures++;
        $display("FAIL idle_outputs cyc=%0d got=%h/%b/%b/%b exp=0", cyc, loadData, loadDataValid, storeComplete, busy);
      end
    end
    do_req(1, 0, 32'h40, 32'hDEADBEEF, 4'hF, 0, 0);
    do_req(0, 1, 32'h40, 32'h0, 4'h0, 1, 32'hDEADBEEF);
    do_req(1, 0, 32'h40, 32'h0000AB00, 4'b0010, 0, 0);
    do_req(0, 1, 32'h40, 32'h0, 4'h0, 1, 32'hDEADABEF);
    do_req(1, 0, 32'h1000, 32'h12345678, 4'hF, 0, 0);
    do_req(0, 1, 32'h0, 32'h0, 4'h0, 1, 32'h12345678);
    do_req(1, 1, 32'h80, 32'h1, 4'hF, 0, 0);
    do_req(0, 1, 32'h80, 32'h0, 4'h0, 1, 32'h1);
    do_req(1, 0, 32'h80, 32'hFFFFFFFF, 4'h0, 0, 0);
    do_req(0, 1, 32'h80, 32'h0, 4'h0, 1, 32'h1);
    address = 32'h40; storeData = 32'hFFFFFFFF; byteEnable = 4'hF; storeValid = 1'b1;
    busy_chk_en = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_wait got=%b exp=1", busy);
    end
    reset = 1'b1;
    storeValid = 1'b0;
    @(negedge clock);
    checks++;
    if ({loadData, loadDataValid, storeComplete, busy} !== 35'h0) begin
      failures++;
      $display("FAIL mid_reset_state got=%h/%b/%b/%b exp=0", loadData, loadDataValid, storeComplete, busy);
    end
    reset = 1'b0;
    repeat (6) @(negedge clock);
    busy_chk_en = 1'b1;
    do_req(0, 1, 32'h40, 32'h0, 4'h0, 1, 32'hDEADABEF);
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom();
      a[11:2] = 10'($urandom_range(0, 15));
      do_req(r < 4 || r == 9, r >= 4, a, $urandom(), 4'($urandom_range(0, 15)), 0, 0);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_at_end got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_latency_responder.md
Name: dmem_latency_responder

Overview:
- Data-memory responder for the Memory stage's load/store request interface: accepts one request at a time, waits a programmable number of cycles, then returns load data or a store completion.
- Gives the Memory stage's stallControl path a realistic wait-state target with byte-enable writes into a word array.
- Instantiated at top level alongside the instruction memory; used in simulation and FPGA builds.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- LATENCY, 2, wait cycles between request acceptance and response; 0 to 15.
- INIT_ZERO, 1, when 1 the array is zero-filled at time 0; when 0 it is left uninitialised.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- address  input  32  byte address from the Memory stage.
- storeData  input  32  write data, lane-aligned.
- byteEnable  input  4  store byte lanes; bit i covers storeData[8i+7:8i].
- storeValid  input  1  store request.
- loadValid  input  1  load request.
- loadData  output  32  load result.
- loadDataValid  output  1  one-cycle load-response pulse.
- storeComplete  output  1  one-cycle store-response pulse.
- busy  output  1  high while a request is outstanding.

Behaviour:
- Reset: state IDLE; counter 0; loadData=0, loadDataValid=0, storeComplete=0, busy=0. Array contents are not cleared by reset.
- Word index is address[2 +: log2(DEPTH_WORDS)]. address[1:0] and the upper bits are ignored, so out-of-range addresses wrap modulo the depth.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE: on storeValid or loadValid, latch address, storeData, byteEnable and the request type, then go to WAIT. If LATENCY=0, go straight to RESPOND. busy rises the cycle after acceptance.
- WAIT: counter counts 1..LATENCY. At LATENCY, go to RESPOND.
- RESPOND (one cycle): the response is issued on the edge entering this state, so the response pulse is high exactly at cycle T+1+LATENCY for a request sampled at edge T.
  - Store: writes the latched lanes whose byteEnable bit is set and pulses storeComplete.
  - Load: drives loadData with the array word and pulses loadDataValid.
  - Next state is IDLE. busy is low in the cycle the pulse is high.
- loadData holds its last value until the next load response; stores do not change it.
- Request inputs are ignored outside IDLE. The requester must hold a request until it sees the response.
- A new request may be accepted in the cycle immediately after the response pulse, provided the request is still asserted in IDLE.
- storeValid and loadValid high together: store wins and the load is dropped, with no load response.
- byteEnable=0 store: no array change; storeComplete still pulses.
- Reset mid-operation: the outstanding request is abandoned, no partial write occurs, no response is issued, and the FSM returns to IDLE.
- loadDataValid and storeComplete are never high in the same cycle.

Optional Feature:
- Macro: DMEM_JITTER_EN.
- Defined: an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) steps once per accepted request. Its low 2 bits add 0-3 extra WAIT cycles to that request's latency.
- Undefined: the latency is exactly LATENCY; no LFSR logic is present.

Test Plan:
- Reset then idle: outputs are all 0 and busy=0 for 10 cycles.
- LATENCY=2: store 32'hDEADBEEF with byteEnable=4'hF to 0x40 at edge T -> storeComplete high at T+3 only. Then a load from 0x40 -> loadDataValid high 3 cycles after acceptance with loadData=32'hDEADBEEF.
- Partial store: byteEnable=4'b0010, storeData=32'h0000AB00 to 0x40, then a load -> loadData=32'hDEADABEF.
- Wrap: with DEPTH_WORDS=1024, store 32'h12345678 to 0x1000, then load from 0x0 -> 32'h12345678.
- Simultaneous storeValid and loadValid to 0x80 with storeData=32'h1 -> only storeComplete pulses. A following load returns 32'h1.
- Reset asserted during WAIT of a store 32'hFFFFFFFF to 0x40 (word holding 32'hDEADABEF) -> no storeComplete. A later load returns 32'hDEADABEF.
